// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit common-anode 7-segment scanner with blanking, PWM and frame snapshots
module seven_seg_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [0:6] Digit0,
  input  logic [0:6] Digit1,
  input  logic [0:6] Digit2,
  input  logic [0:6] Digit3,
  input  logic [3:0] DpIn,
  input  logic [2:0] Brightness,
  output logic [0:6] Seg,
  output logic       Dp,
  output logic [3:0] Anode,
  output logic       FrameDone
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST_C  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CW-1:0]    c_q, c_d;
  logic [2:0]       p_q, p_d;

  logic [3:0][0:6]  dig_q, dig_d;
  logic [3:0]       dps_q, dps_d;
  logic [2:0]       br_q, br_d;

  logic [0:6]       seg_q, seg_d;
  logic             dpo_q, dpo_d;
  logic [3:0]       anode_q, anode_d;
  logic             fd_q, fd_d;

  // First cycle of a frame: the live inputs become the frame's shadow values, and
  // they are forwarded so a zero-length blanking window still shows fresh data.
  logic             snap;
  logic [3:0][0:6]  dig_eff;
  logic [3:0]       dps_eff;
  logic [2:0]       br_eff;
  logic             lit;

  assign snap    = (state_q == SCAN) && (idx_q == 2'd0) && (c_q == '0);
  assign dig_eff = snap ? {Digit3, Digit2, Digit1, Digit0} : dig_q;
  assign dps_eff = snap ? DpIn : dps_q;
  assign br_eff  = snap ? Brightness : br_q;

  // State, counters, shadow copies and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= '0;
      p_q     <= '0;
      dig_q   <= '0;
      dps_q   <= '0;
      br_q    <= '0;
      seg_q   <= '1;
      dpo_q   <= 1'b1;
      anode_q <= 4'hF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      p_q     <= p_d;
      dig_q   <= dig_d;
      dps_q   <= dps_d;
      br_q    <= br_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      anode_q <= anode_d;
      fd_q    <= fd_d;
    end
  end

  // Next state: slot counter, digit index and PWM phase; dropping Enable zeroes everything
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    p_d     = p_q;
    dig_d   = dig_eff;
    dps_d   = dps_eff;
    br_d    = br_eff;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        c_d   = '0;
        p_d   = '0;
        if (Enable) state_d = SCAN;
      end
      SCAN: begin
        if (!Enable) begin
          state_d = IDLE;
          idx_d   = '0;
          c_d     = '0;
          p_d     = '0;
        end else if (c_q == LAST_C) begin
          c_d   = '0;
          idx_d = idx_q + 2'd1;
          p_d   = '0;
        end else begin
          c_d = c_q + CW'(1);
          p_d = (c_q < BLANK_C) ? 3'd0 : p_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: dark while blanking or idle, PWM-gated anode during the lit part of a slot
  always_comb begin
    lit     = (state_q == SCAN) && Enable && (c_q >= BLANK_C);
    seg_d   = '1;
    dpo_d   = 1'b1;
    anode_d = 4'hF;
    fd_d    = 1'b0;
    if (lit) begin
      seg_d = ~dig_eff[idx_q];
      dpo_d = ~dps_eff[idx_q];
      if (p_q <= br_eff) anode_d = ~(4'b0001 << idx_q);
    end
    if ((state_q == SCAN) && Enable && (idx_q == 2'd3) && (c_q == LAST_C)) fd_d = 1'b1;
  end

  assign Seg       = seg_q;
  assign Dp        = dpo_q;
  assign Anode     = anode_q;
  assign FrameDone = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  localparam int SD = 8;
  localparam int BL = 2;

  logic       Clk = 1'b0;
  logic       Reset, Enable;
  logic [0:6] Digit0, Digit1, Digit2, Digit3;
  logic [3:0] DpIn;
  logic [2:0] Brightness;
  logic [0:6] Seg;
  logic       Dp;
  logic [3:0] Anode;
  logic       FrameDone;

  always #5 Clk = ~Clk;

  seven_seg_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .Digit0(Digit0), .Digit1(Digit1), .Digit2(Digit2), .Digit3(Digit3),
    .DpIn(DpIn), .Brightness(Brightness),
    .Seg(Seg), .Dp(Dp), .Anode(Anode), .FrameDone(FrameDone)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] br;
    logic [0:6] dig;
    logic       dp;
    logic [5:0] mask;
    logic [0:6] seg;
    logic       dpo;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Reset with Enable high; cycle 1 is the IDLE->SCAN cycle, output of slot c=0 appears at cycle 2
  task automatic restart();
    Reset  = 1'b1;
    Enable = 1'b1;
    tick();
    Reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic chk_off(input string name);
    chk(name, {Seg, Dp, Anode, FrameDone}, {7'h7F, 1'b1, 4'hF, 1'b0});
  endtask

  // Reference model state
  int         m_scan, m_t;
  logic [0:6] sd [4];
  logic [3:0] sdp;
  logic [2:0] sbr;
  logic [0:6] es;
  logic       ed, ef;
  logic [3:0] ea;
  logic [0:6] pseg;
  logic       pdp;
  logic [3:0] pan;

  task automatic model_step();
    int c, i, p;
    es = 7'h7F; ed = 1'b1; ea = 4'hF; ef = 1'b0;
    if (Reset) begin
      m_scan = 0;
    end else if (m_scan == 0) begin
      if (Enable) begin m_scan = 1; m_t = 0; end
    end else if (!Enable) begin
      m_scan = 0;
    end else begin
      c = m_t % SD;
      i = (m_t / SD) % 4;
      if (m_t % (4 * SD) == 0) begin
        sd[0] = Digit0; sd[1] = Digit1; sd[2] = Digit2; sd[3] = Digit3;
        sdp = DpIn; sbr = Brightness;
      end
      if (c >= BL) begin
        p  = (c - BL) % 8;
        es = ~sd[i];
        ed = ~sdp[i];
        if (p <= int'(sbr)) ea = 4'hF & ~(4'b0001 << i);
      end
      ef = (i == 3) && (c == SD - 1);
      m_t++;
    end
  endtask

  initial begin
    logic [3:0] an_exp;
    int         npulse, last;
    logic       fd_seen;

    vt[0] = '{3'd7, 7'b1111110, 1'b0, 6'b111111, 7'b0000001, 1'b1};
    vt[1] = '{3'd1, 7'b1111110, 1'b0, 6'b000011, 7'b0000001, 1'b1};
    vt[2] = '{3'd0, 7'b0110000, 1'b1, 6'b000001, 7'b1001111, 1'b0};
    vt[3] = '{3'd5, 7'b1101101, 1'b0, 6'b111111, 7'b0010010, 1'b1};
    vt[4] = '{3'd3, 7'b1111001, 1'b1, 6'b001111, 7'b0000110, 1'b0};
    vt[5] = '{3'd2, 7'b0110011, 1'b0, 6'b000111, 7'b1001100, 1'b1};

    Reset = 1'b1; Enable = 1'b0;
    Digit0 = '0; Digit1 = '0; Digit2 = '0; Digit3 = '0;
    DpIn = '0; Brightness = 3'd7;
    tick();
    tick();
    chk_off("reset_state");

    // Table-driven first frame: blanking, PWM duty, segment/dp polarity and FrameDone position
    for (int v = 0; v < 6; v++) begin
      Digit0 = vt[v].dig; Digit1 = vt[v].dig; Digit2 = vt[v].dig; Digit3 = vt[v].dig;
      DpIn = {4{vt[v].dp}};
      Brightness = vt[v].br;
      restart();
      tick();
      chk_off("idle_to_scan");
      for (int d = 0; d < 4; d++) begin
        for (int k = 0; k < SD; k++) begin
          tick();
          if (k < BL) begin
            chk("blank_anode", Anode, 4'hF);
            chk("blank_seg", {Seg, Dp}, {7'h7F, 1'b1});
          end else begin
            an_exp = vt[v].mask[k - BL] ? (4'hF & ~(4'b0001 << d)) : 4'hF;
            chk("pwm_anode", Anode, an_exp);
            chk("lit_seg", {Seg, Dp}, {vt[v].seg, vt[v].dpo});
          end
          chk("framedone_pos", FrameDone, (cyc == 33));
        end
      end
      if (v == 0) begin
        npulse = 0; last = 0;
        while (cyc < 65) begin
          tick();
          if (FrameDone) begin npulse++; last = cyc; end
        end
        chk("framedone_count", npulse, 1);
        chk("framedone_period", last, 65);
      end
    end

    // Snapshot: Digit2 changed during digit-1 slot shows up only in the next frame
    Brightness = 3'd7; DpIn = 4'h0;
    Digit0 = 7'b1111110; Digit1 = 7'b0110000; Digit2 = 7'b1011011; Digit3 = 7'b1111001;
    restart();
    run_to(12);
    Digit2 = 7'b0011111;
    run_to(21);
    chk("snap_old_seg", Seg, 7'b0100100);
    chk("snap_old_anode", Anode, 4'b1011);
    run_to(53);
    chk("snap_new_seg", Seg, 7'b1100000);
    chk("snap_new_anode", Anode, 4'b1011);

    // Enable dropped during digit-2 lit phase, then re-raised
    restart();
    run_to(21);
    Enable = 1'b0;
    tick();
    chk_off("disable_off");
    fd_seen = 1'b0;
    while (cyc < 40) begin
      tick();
      if (FrameDone) fd_seen = 1'b1;
    end
    chk("disable_no_framedone", fd_seen, 1'b0);
    Enable = 1'b1;
    tick();
    chk("reenable_idle", Anode, 4'hF);
    tick();
    chk("reenable_blank0", Anode, 4'hF);
    tick();
    chk("reenable_blank1", Anode, 4'hF);
    tick();
    chk("reenable_digit0", {Seg, Anode}, {7'b0000001, 4'b1110});

    // One-cycle reset in the middle of the digit-3 slot
    restart();
    run_to(28);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_off("midreset_off");
    fd_seen = 1'b0;
    while (cyc < 40) begin
      tick();
      if (FrameDone) fd_seen = 1'b1;
      if (cyc == 32) chk("midreset_blank", Anode, 4'hF);
      if (cyc == 33) chk("midreset_restart", {Seg, Anode}, {7'b0000001, 4'b1110});
    end
    chk("midreset_no_framedone", fd_seen, 1'b0);

    // Randomized run against the reference model, roughly 1000 frames
    Reset = 1'b1; Enable = 1'b1;
    m_scan = 0; m_t = 0;
    pan = 4'hF; pseg = 7'h7F; pdp = 1'b1;
    for (int n = 0; n < 4 * SD * 1000 + 2000; n++) begin
      if (n > 0) Reset = ($urandom_range(0, 4999) == 0);
      if (Enable && $urandom_range(0, 2999) == 0) Enable = 1'b0;
      else if (!Enable && $urandom_range(0, 19) == 0) Enable = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        Digit0 = 7'($urandom); Digit1 = 7'($urandom);
        Digit2 = 7'($urandom); Digit3 = 7'($urandom);
        DpIn = 4'($urandom); Brightness = 3'($urandom);
      end
      model_step();
      tick();
      chk("rand_outputs", {Seg, Dp, Anode, FrameDone}, {es, ed, ea, ef});
      chk("rand_onehot", ($countones(~Anode) <= 1), 1'b1);
      if (pan != 4'hF && Anode != 4'hF) chk("rand_seg_stable", {Seg, Dp}, {pseg, pdp});
      pan = Anode; pseg = Seg; pdp = Dp;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
